lcd_spi_streamer: RTL and testbench

LCD_SPI_STREAMER -- requirements
Module: lcd_spi_streamer

---
 rtl/lcd_spi_streamer.sv | 189 ++++++++++++++++++
 tb/tb_lcd_spi_streamer.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_streamer.sv
// Word FIFO feeding a mode-0 SPI shifter for an LCD panel, with D/C per word
// and a panel reset sequencer that drives res_n before any transfer.
module lcd_spi_streamer #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int RST_LOW    = 100,
    parameter int RST_WAIT   = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_dc,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          lcd_reset_req,
    output logic                          sclk,
    output logic                          mosi,
    output logic                          cs_n,
    output logic                          dc,
    output logic                          res_n,
    output logic                          busy,
    output logic                          byte_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int RMAX = (RST_LOW > RST_WAIT) ? RST_LOW : RST_WAIT;
    localparam int CW   = $clog2(RMAX + 1);
    localparam int BW   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_RST_HOLD, S_RST_WAIT, S_IDLE, S_LOAD, S_SHIFT, S_CS_HOLD, S_GAP
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       rst_cnt_q;
    logic [7:0]          div_cnt_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [DATA_W-2:0]   rest_q;
    logic                sclk_q, mosi_q, cs_n_q, dc_q, res_n_q, byte_done_q;

    logic [DATA_W:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q, count_d;
    logic [DATA_W:0]     head;
    logic                fifo_empty, push, pop, tick, last_bit, word_end;

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign tick       = (div_cnt_q == 8'(CLK_DIV - 1));
    assign last_bit   = (bit_cnt_q == BW'(DATA_W - 1));
    assign word_end   = (state_q == S_SHIFT) && tick && sclk_q && last_bit;
    // The engine takes a word either to start a frame or to continue one seamlessly.
    assign pop        = !lcd_reset_req && !fifo_empty && ((state_q == S_IDLE) || word_end);
    assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_dc, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        byte_done_q <= 1'b0;
        if (rst) begin
            state_q   <= S_RST_HOLD;
            rst_cnt_q <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            rest_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
            res_n_q   <= 1'b0;
        end else if (lcd_reset_req) begin
            state_q   <= S_RST_HOLD;
            rst_cnt_q <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            res_n_q   <= 1'b0;
        end else begin
            case (state_q)
                S_RST_HOLD: begin
                    if (rst_cnt_q == CW'(RST_LOW - 1)) begin
                        rst_cnt_q <= '0;
                        res_n_q   <= 1'b1;
                        state_q   <= S_RST_WAIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (rst_cnt_q == CW'(RST_WAIT - 1)) begin
                        rst_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= S_LOAD;
                        rest_q    <= head[DATA_W-2:0];
                        mosi_q    <= head[DATA_W-1];
                        dc_q      <= head[DATA_W];
                        cs_n_q    <= 1'b0;
                        sclk_q    <= 1'b0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                // LOAD is the first low-phase cycle of bit 0, so it shares the divider.
                S_LOAD, S_SHIFT: begin
                    state_q <= S_SHIFT;
                    if (tick) begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (last_bit) begin
                                byte_done_q <= 1'b1;
                                bit_cnt_q   <= '0;
                                if (!fifo_empty) begin
                                    rest_q <= head[DATA_W-2:0];
                                    mosi_q <= head[DATA_W-1];
                                    dc_q   <= head[DATA_W];
                                end else begin
                                    state_q <= S_CS_HOLD;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                mosi_q    <= rest_q[DATA_W-2];
                                rest_q    <= rest_q << 1;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_CS_HOLD: begin
                    if (tick) begin
                        div_cnt_q <= '0;
                        cs_n_q    <= 1'b1;
                        state_q   <= S_GAP;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        div_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_RST_HOLD;
            endcase
        end
    end

    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;
    assign dc         = dc_q;
    assign res_n      = res_n_q;
    assign byte_done  = byte_done_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_lcd_spi_streamer.sv
// Bench for lcd_spi_streamer: a bus monitor decodes SPI words and event times,
// and each scenario task compares them against expectations derived from timing rules.
module tb_lcd_spi_streamer;
    localparam int DATA_W     = 8;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int RST_LOW    = 4;
    localparam int RST_WAIT   = 6;
    localparam int BIT_T      = 2 * CLK_DIV;
    localparam int WORD_T     = DATA_W * BIT_T;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_dc = 1'b0;
    logic              in_valid = 1'b0;
    logic              lcd_reset_req = 1'b0;
    wire               in_ready, sclk, mosi, cs_n, dc, res_n, busy, byte_done;
    wire [2:0]         fifo_count;

    lcd_spi_streamer #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH),
        .RST_LOW(RST_LOW), .RST_WAIT(RST_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dc(in_dc), .in_valid(in_valid),
        .in_ready(in_ready), .lcd_reset_req(lcd_reset_req), .sclk(sclk), .mosi(mosi),
        .cs_n(cs_n), .dc(dc), .res_n(res_n), .busy(busy), .byte_done(byte_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rise_q[$], fall_q[$], csf_q[$], csr_q[$], bd_q[$], dcchg_q[$];
    logic [DATA_W:0] got_q[$];
    int dc_viol = 0;

    // Bus monitor: event cycle stamps and decoded {dc, data} words.
    initial begin
        logic p_sclk, p_cs, p_dc, wdc;
        logic [DATA_W-1:0] sh;
        int nb;
        p_sclk = 1'b0; p_cs = 1'b1; p_dc = 1'b0; wdc = 1'b0; sh = '0; nb = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (p_cs && !cs_n) csf_q.push_back(cyc);
                if (!p_cs && cs_n) csr_q.push_back(cyc);
                if (p_sclk && !sclk) fall_q.push_back(cyc);
                if (byte_done) bd_q.push_back(cyc);
                if (dc != p_dc) begin
                    dcchg_q.push_back(cyc);
                    if (!cs_n && sclk) dc_viol++;
                end
                if (cs_n || !res_n) begin
                    nb = 0;
                end else if (!p_sclk && sclk) begin
                    rise_q.push_back(cyc);
                    if (nb == 0) wdc = dc;
                    sh = {sh[DATA_W-2:0], mosi};
                    nb++;
                    if (nb == DATA_W) begin
                        got_q.push_back({wdc, sh});
                        nb = 0;
                    end
                end
            end else begin
                nb = 0;
            end
            p_sclk = sclk; p_cs = cs_n; p_dc = dc;
        end
    end

    task automatic clear_mon();
        rise_q.delete(); fall_q.delete(); csf_q.delete(); csr_q.delete();
        bd_q.delete(); dcchg_q.delete(); got_q.delete(); dc_viol = 0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r0;
        logic exp_res, exp_busy;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; lcd_reset_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sclk, mosi, cs_n, dc, res_n, byte_done, busy, in_ready} !== 8'b0010_0011) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00100011",
                     {sclk, mosi, cs_n, dc, res_n, byte_done, busy, in_ready});
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; lcd_reset_req = 1'b0;
        r0 = cyc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_res  = (i >= RST_LOW);
            exp_busy = (i < RST_LOW + RST_WAIT);
            checks++;
            if (res_n !== exp_res || busy !== exp_busy || cs_n !== 1'b1) begin
                errors++;
                $display("FAIL reset_seq cycle %0d: got res_n=%b busy=%b cs_n=%b expected res_n=%b busy=%b cs_n=1",
                         cyc - r0, res_n, busy, cs_n, exp_res, exp_busy);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int t;
        bit ok;
        clear_mon();
        @(posedge clk); #1;
        t = cyc; in_data = 8'hA5; in_dc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: busy never dropped"); end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_word: got %0d words first=%h expected 1 word 1a5", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 9'h0);
        end
        checks++;
        if (csf_q.size() != 1 || csf_q[0] != t + 2) begin
            errors++;
            $display("FAIL single_cs_fall: got %0d expected %0d", csf_q.size() > 0 ? csf_q[0] - t : -1, 2);
        end
        checks++;
        if (rise_q.size() != DATA_W || rise_q[0] != t + 2 + CLK_DIV) begin
            errors++;
            $display("FAIL single_first_rise: got n=%0d at %0d expected n=%0d at %0d", rise_q.size(),
                     rise_q.size() > 0 ? rise_q[0] - t : -1, DATA_W, 2 + CLK_DIV);
        end
        checks++;
        if (bd_q.size() != 1 || bd_q[0] != t + 2 + WORD_T) begin
            errors++;
            $display("FAIL single_byte_done: got n=%0d at %0d expected n=1 at %0d", bd_q.size(),
                     bd_q.size() > 0 ? bd_q[0] - t : -1, 2 + WORD_T);
        end
        checks++;
        if (csr_q.size() != 1 || csr_q[0] != t + 2 + WORD_T + CLK_DIV) begin
            errors++;
            $display("FAIL single_cs_rise: got %0d expected %0d",
                     csr_q.size() > 0 ? csr_q[0] - t : -1, 2 + WORD_T + CLK_DIV);
        end
        checks++;
        if (dcchg_q.size() != 1 || dc_viol != 0) begin
            errors++;
            $display("FAIL single_dc: got %0d changes %0d violations expected 1 and 0",
                     dcchg_q.size(), dc_viol);
        end
        $display("test_single done");
    endtask

    task automatic test_burst();
        bit ok;
        int bad_gap;
        clear_mon();
        @(posedge clk); #1;
        in_data = 8'h2A; in_dc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h00; in_dc = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL burst_timeout: busy never dropped"); end
        bad_gap = 0;
        for (int i = 1; i < rise_q.size(); i++)
            if (rise_q[i] - rise_q[i-1] != BIT_T) bad_gap++;
        checks++;
        if (rise_q.size() != 2 * DATA_W || bad_gap != 0) begin
            errors++;
            $display("FAIL burst_sclk: got %0d rises %0d gaps expected %0d rises 0 gaps",
                     rise_q.size(), bad_gap, 2 * DATA_W);
        end
        checks++;
        if (csf_q.size() != 1 || csr_q.size() != 1) begin
            errors++;
            $display("FAIL burst_cs: got %0d falls %0d rises expected 1 and 1", csf_q.size(), csr_q.size());
        end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {1'b0, 8'h2A} || got_q[1] !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL burst_words: got n=%0d expected 02a then 100", got_q.size());
        end
        checks++;
        if (bd_q.size() != 2 || bd_q[1] - bd_q[0] != WORD_T) begin
            errors++;
            $display("FAIL burst_byte_done: got n=%0d spacing %0d expected 2 spacing %0d", bd_q.size(),
                     bd_q.size() == 2 ? bd_q[1] - bd_q[0] : -1, WORD_T);
        end
        checks++;
        if (fall_q.size() < DATA_W || dcchg_q.size() == 0 || dcchg_q[dcchg_q.size()-1] != fall_q[DATA_W-1]
            || dc_viol != 0) begin
            errors++;
            $display("FAIL burst_dc_switch: got last dc change at %0d violations %0d expected at %0d and 0",
                     dcchg_q.size() > 0 ? dcchg_q[dcchg_q.size()-1] : -1, dc_viol,
                     fall_q.size() >= DATA_W ? fall_q[DATA_W-1] : -1);
        end
        $display("test_burst done");
    endtask

    task automatic test_full_fifo();
        int t, c, mcount, bad;
        bit push, pop, ok;
        logic [DATA_W:0] acc[$];
        clear_mon();
        @(posedge clk); #1;
        t = cyc; mcount = 0; in_valid = 1'b1;
        in_data = DATA_W'($urandom); in_dc = 1'($urandom);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            c = cyc;
            checks++;
            if (fifo_count !== 3'(mcount) || in_ready !== (mcount < FIFO_DEPTH)) begin
                errors++;
                $display("FAIL full_count cycle %0d: got count=%0d ready=%b expected count=%0d ready=%b",
                         c - t, fifo_count, in_ready, mcount, mcount < FIFO_DEPTH);
            end
            push = (mcount < FIFO_DEPTH);
            pop  = (c >= t + 1) && (((c - t - 1) % WORD_T) == 0);
            if (push) acc.push_back({in_dc, in_data});
            mcount = mcount + int'(push) - int'(pop);
            @(posedge clk); #1;
            in_data = DATA_W'($urandom); in_dc = 1'($urandom);
        end
        in_valid = 1'b0;
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout: busy never dropped"); end
        bad = 0;
        for (int i = 0; i < acc.size() && i < got_q.size(); i++)
            if (got_q[i] !== acc[i]) bad++;
        checks++;
        if (got_q.size() != acc.size() || bad != 0) begin
            errors++;
            $display("FAIL full_words: got %0d words %0d wrong expected %0d words",
                     got_q.size(), bad, acc.size());
        end
        $display("test_full_fifo done: %0d words", acc.size());
    endtask

    task automatic test_abort();
        logic [DATA_W:0] w[3];
        int a;
        bit ok;
        clear_mon();
        for (int i = 0; i < 3; i++) w[i] = {1'($urandom), DATA_W'($urandom)};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            {in_dc, in_data} = w[i]; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rise_q.size() >= 3) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_wait_rise: got %0d rises expected 3", rise_q.size()); end
        @(posedge clk); #1;
        a = cyc; lcd_reset_req = 1'b1;
        @(posedge clk); #1;
        lcd_reset_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cs_n, sclk, res_n, byte_done} !== 4'b1000 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL abort_outputs: got cs_n=%b sclk=%b res_n=%b byte_done=%b count=%0d expected 1 0 0 0 count=2",
                     cs_n, sclk, res_n, byte_done, fifo_count);
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (csf_q.size() >= 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || csf_q[1] != a + RST_LOW + RST_WAIT + 2) begin
            errors++;
            $display("FAIL abort_restart_time: got %0d expected %0d",
                     csf_q.size() >= 2 ? csf_q[1] - a : -1, RST_LOW + RST_WAIT + 2);
        end
        wait_idle(400, ok);
        checks++;
        if (!ok || got_q.size() != 2 || got_q[0] !== w[1] || got_q[1] !== w[2] || bd_q.size() != 2) begin
            errors++;
            $display("FAIL abort_words: got %0d words %0d byte_done expected %h %h and 2",
                     got_q.size(), bd_q.size(), w[1], w[2]);
        end
        $display("test_abort done");
    endtask

    task automatic test_restart();
        int r0, a;
        bit ok;
        logic [DATA_W:0] w;
        w = {1'($urandom), DATA_W'($urandom)};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        r0 = cyc;
        @(posedge clk); #1;
        {in_dc, in_data} = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1 || cs_n !== 1'b1 || res_n !== 1'b0) begin
            errors++;
            $display("FAIL restart_held: got count=%0d cs_n=%b res_n=%b expected 1 1 0", fifo_count, cs_n, res_n);
        end
        repeat (4) @(posedge clk);
        #1;
        a = cyc; lcd_reset_req = 1'b1;
        @(posedge clk); #1;
        lcd_reset_req = 1'b0;
        repeat (RST_LOW - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (res_n !== 1'b0 || a - r0 != RST_LOW + 2) begin
            errors++;
            $display("FAIL restart_res_low: got res_n=%b at req offset %0d expected 0 at %0d",
                     res_n, a - r0, RST_LOW + 2);
        end
        @(negedge clk);
        checks++;
        if (res_n !== 1'b1) begin
            errors++;
            $display("FAIL restart_res_high: got %b expected 1", res_n);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok || csf_q.size() != 1 || csf_q[0] != a + RST_LOW + RST_WAIT + 2 || got_q.size() != 1
            || got_q[0] !== w) begin
            errors++;
            $display("FAIL restart_transfer: got start %0d words %0d expected start %0d word %h",
                     csf_q.size() > 0 ? csf_q[0] - a : -1, got_q.size(), RST_LOW + RST_WAIT + 2, w);
        end
        $display("test_restart done");
    endtask

    task automatic test_rst_mid();
        bit ok;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_data = DATA_W'($urandom); in_dc = 1'($urandom); in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rise_q.size() >= 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || fifo_count === 3'd0) begin
            errors++;
            $display("FAIL rstmid_setup: got rises=%0d count=%0d expected 2 rises and nonzero count",
                     rise_q.size(), fifo_count);
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; lcd_reset_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sclk, mosi, cs_n, dc, res_n, byte_done, busy, in_ready} !== 8'b0010_0011 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b count=%0d expected 00100011 count=0",
                     {sclk, mosi, cs_n, dc, res_n, byte_done, busy, in_ready}, fifo_count);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; lcd_reset_req = 1'b0;
        clear_mon();
        wait_idle(50, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || csf_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_flushed: got idle=%b frames=%0d count=%0d expected 1 0 0",
                     ok, csf_q.size(), fifo_count);
        end
        $display("test_rst_mid done");
    endtask

    task automatic test_random_stream();
        logic [DATA_W:0] exp_q[$];
        bit ok;
        int bad;
        clear_mon();
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            in_data = DATA_W'($urandom); in_dc = 1'($urandom); in_valid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    exp_q.push_back({in_dc, in_data});
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (!ok) begin errors++; $display("FAIL stream_handshake word %0d: in_ready never high", k); end
        end
        wait_idle(1000, ok);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stream_word %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (!ok || got_q.size() != exp_q.size() || bd_q.size() != exp_q.size() || bad != 0 || dc_viol != 0) begin
            errors++;
            $display("FAIL stream_summary: got %0d words %0d byte_done %0d wrong %0d dc violations expected %0d 0 0",
                     got_q.size(), bd_q.size(), bad, dc_viol, exp_q.size());
        end
        $display("test_random_stream done: %0d words", exp_q.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_fifo();
        test_abort();
        test_restart();
        test_rst_mid();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
